// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared states, grant ids and counter width for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC_D = 2'd1,
    S_ACC_I = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-bus signals of the shared memory port
// slave  : arbiter side (takes IF/MEM requests and Mem_Rdata, drives the rest)
// master : pipeline + memory side (the mirror image)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic              IF_Req;
  logic [ADDR_W-1:0] IF_Addr;
  logic [DATA_W-1:0] IF_Data;
  logic              IF_Ready;
  logic              IF_Freeze;

  logic              MEM_R_En;
  logic              MEM_W_En;
  logic [ADDR_W-1:0] MEM_Addr;
  logic [DATA_W-1:0] MEM_Wdata;
  logic [DATA_W-1:0] MEM_Rdata;
  logic              MEM_Ready;
  logic              MEM_Freeze;

  logic              Mem_En;
  logic              Mem_Wr;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Wdata;
  logic [DATA_W-1:0] Mem_Rdata;

  modport slave (
    input  IF_Req, IF_Addr, MEM_R_En, MEM_W_En, MEM_Addr, MEM_Wdata, Mem_Rdata,
    output IF_Data, IF_Ready, IF_Freeze, MEM_Rdata, MEM_Ready, MEM_Freeze,
           Mem_En, Mem_Wr, Mem_Addr, Mem_Wdata
  );

  modport master (
    output IF_Req, IF_Addr, MEM_R_En, MEM_W_En, MEM_Addr, MEM_Wdata, Mem_Rdata,
    input  IF_Data, IF_Ready, IF_Freeze, MEM_Rdata, MEM_Ready, MEM_Freeze,
           Mem_En, Mem_Wr, Mem_Addr, Mem_Wdata
  );
endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// rtl/mem_port_arbiter_wait_counter.sv - load/decrement wait-cycle counter with zero flag
// clk, rst : clock, synchronous active-high reset
// load     : load load_val (has priority over dec)
// dec      : decrement, saturating at zero
// zero     : counter is zero
module mem_wait_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter/sequencer for the shared IF/MEM memory port
// clk, rst : clock, synchronous active-high reset
// bus      : slave side of mem_port_arbiter_if (IF_*, MEM_* requesters and Mem_* memory bus)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0] acc_wdata_q, acc_wdata_d;
  logic              acc_wr_q, acc_wr_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic data_req;
  logic gnt_sel;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  assign data_req = bus.MEM_R_En | bus.MEM_W_En;

  mem_wait_counter u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    acc_addr_d   = acc_addr_q;
    acc_wdata_d  = acc_wdata_q;
    acc_wr_d     = acc_wr_q;
    if_data_d    = if_data_q;
    mem_rdata_d  = mem_rdata_q;
    gnt_sel      = GNT_I;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_req || bus.IF_Req) begin
          // On a tie the requester served less recently wins.
          if (data_req && bus.IF_Req) begin
            gnt_sel = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
          end else begin
            gnt_sel = data_req ? GNT_D : GNT_I;
          end
          cnt_load = 1'b1;
          if (gnt_sel == GNT_D) begin
            state_d     = S_ACC_D;
            acc_addr_d  = bus.MEM_Addr;
            acc_wdata_d = bus.MEM_Wdata;
            acc_wr_d    = bus.MEM_W_En;
          end else begin
            state_d     = S_ACC_I;
            acc_addr_d  = bus.IF_Addr;
            acc_wdata_d = '0;
            acc_wr_d    = 1'b0;
          end
        end
      end

      S_ACC_D, S_ACC_I: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = S_DONE;
          // last_grant doubles as the "who finished" selector for Ready in DONE.
          if (state_q == S_ACC_D) begin
            last_grant_d = GNT_D;
            if (!acc_wr_q) begin
              mem_rdata_d = bus.Mem_Rdata;
            end
          end else begin
            last_grant_d = GNT_I;
            if_data_d    = bus.Mem_Rdata;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_I;
      acc_addr_q   <= '0;
      acc_wdata_q  <= '0;
      acc_wr_q     <= 1'b0;
      if_data_q    <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      acc_addr_q   <= acc_addr_d;
      acc_wdata_q  <= acc_wdata_d;
      acc_wr_q     <= acc_wr_d;
      if_data_q    <= if_data_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  // Memory bus comes only from state and the latched access, never from requester inputs.
  assign bus.Mem_En    = (state_q == S_ACC_D) || (state_q == S_ACC_I);
  assign bus.Mem_Wr    = (state_q == S_ACC_D) && acc_wr_q;
  assign bus.Mem_Addr  = acc_addr_q;
  assign bus.Mem_Wdata = acc_wdata_q;

  assign bus.IF_Ready  = (state_q == S_DONE) && (last_grant_q == GNT_I);
  assign bus.MEM_Ready = (state_q == S_DONE) && (last_grant_q == GNT_D);
  assign bus.IF_Data   = if_data_q;
  assign bus.MEM_Rdata = mem_rdata_q;

  // Freeze is combinational so the pipeline stalls in the same cycle the request appears;
  // it is forced low while reset is held so every output reads 0 in reset.
  assign bus.IF_Freeze  = bus.IF_Req & ~bus.IF_Ready & ~rst;
  assign bus.MEM_Freeze = data_req & ~bus.MEM_Ready & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(18), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(18), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(18), .DATA_W(32), .WAIT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_port_arbiter #(.ADDR_W(18), .DATA_W(32), .WAIT_CYC(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Memory model: a few fixed words plus a writable array.
  logic [31:0] wr_mem [0:255];

  always @(posedge clk) begin
    if (bus.Mem_En && bus.Mem_Wr) begin
      wr_mem[bus.Mem_Addr[7:0]] <= bus.Mem_Wdata;
    end
  end

  function automatic logic [31:0] mem_rd(input logic [17:0] a);
    case (a)
      18'h10:  mem_rd = 32'hDEADBEEF;
      18'h30:  mem_rd = 32'hA5A50001;
      18'h40:  mem_rd = 32'h0BADF00D;
      default: mem_rd = wr_mem[a[7:0]];
    endcase
  endfunction

  assign bus.Mem_Rdata  = mem_rd(bus.Mem_Addr);
  assign bus1.Mem_Rdata = mem_rd(bus1.Mem_Addr);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where the request is sampled; returns in the Ready cycle.
  task automatic access(input string tag, input bit gnt_d, input logic [17:0] addr,
                        input bit wr, input logic [31:0] wdata, input logic [31:0] exp_rd);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_eq({tag, "_en"}, 32'(bus.Mem_En), 32'd1);
      check_eq({tag, "_addr"}, 32'(bus.Mem_Addr), 32'(addr));
      check_eq({tag, "_wr"}, 32'(bus.Mem_Wr), 32'(wr));
      if (wr) check_eq({tag, "_wdata"}, bus.Mem_Wdata, wdata);
      check_eq({tag, "_rdy_early"}, 32'({bus.IF_Ready, bus.MEM_Ready}), 32'd0);
    end
    tick();
    check_eq({tag, "_if_rdy"}, 32'(bus.IF_Ready), 32'(!gnt_d));
    check_eq({tag, "_mem_rdy"}, 32'(bus.MEM_Ready), 32'(gnt_d));
    check_eq({tag, "_en_off"}, 32'(bus.Mem_En), 32'd0);
    if (gnt_d) check_eq({tag, "_mem_rdata"}, bus.MEM_Rdata, exp_rd);
    else       check_eq({tag, "_if_data"}, bus.IF_Data, exp_rd);
    check_eq({tag, "_if_frz"}, 32'(bus.IF_Freeze), 32'(bus.IF_Req & gnt_d));
    check_eq({tag, "_mem_frz"}, 32'(bus.MEM_Freeze), 32'((bus.MEM_R_En | bus.MEM_W_En) & !gnt_d));
  endtask

  initial begin
    rst = 1'b1;
    bus.IF_Req = 1'b1;   bus.IF_Addr = 18'h10;
    bus.MEM_R_En = 1'b1; bus.MEM_W_En = 1'b0;
    bus.MEM_Addr = 18'h30; bus.MEM_Wdata = 32'h0;
    bus1.IF_Req = 1'b0;  bus1.IF_Addr = 18'h0;
    bus1.MEM_R_En = 1'b0; bus1.MEM_W_En = 1'b0;
    bus1.MEM_Addr = 18'h0; bus1.MEM_Wdata = 32'h0;

    // Reset held two cycles with both requests asserted.
    tick();
    tick();
    check_eq("rst_mem_en", 32'(bus.Mem_En), 32'd0);
    check_eq("rst_mem_wr", 32'(bus.Mem_Wr), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.Mem_Addr), 32'd0);
    check_eq("rst_mem_wdata", bus.Mem_Wdata, 32'd0);
    check_eq("rst_ready", 32'({bus.IF_Ready, bus.MEM_Ready}), 32'd0);
    check_eq("rst_freeze", 32'({bus.IF_Freeze, bus.MEM_Freeze}), 32'd0);
    check_eq("rst_if_data", bus.IF_Data, 32'd0);
    check_eq("rst_mem_rdata", bus.MEM_Rdata, 32'd0);
    check_eq("rst_dut1_en", 32'(bus1.Mem_En), 32'd0);

    // rst falls: cycle 0 of the first tie; data wins, then strict alternation.
    rst = 1'b0;
    #1;
    check_eq("c0_if_frz", 32'(bus.IF_Freeze), 32'd1);
    check_eq("c0_mem_frz", 32'(bus.MEM_Freeze), 32'd1);
    access("tie1_d", 1'b1, 18'h30, 1'b0, 32'h0, 32'hA5A50001);
    tick();
    access("tie2_i", 1'b0, 18'h10, 1'b0, 32'h0, 32'hDEADBEEF);
    tick();
    access("tie3_d", 1'b1, 18'h30, 1'b0, 32'h0, 32'hA5A50001);
    tick();
    access("tie4_i", 1'b0, 18'h10, 1'b0, 32'h0, 32'hDEADBEEF);
    bus.IF_Req = 1'b0;
    bus.MEM_R_En = 1'b0;
    tick();
    tick();
    check_eq("idle_en", 32'(bus.Mem_En), 32'd0);

    // Write then read back; a write leaves MEM_Rdata alone.
    bus.MEM_W_En = 1'b1; bus.MEM_Addr = 18'h20; bus.MEM_Wdata = 32'h12345678;
    access("wr", 1'b1, 18'h20, 1'b1, 32'h12345678, 32'hA5A50001);
    bus.MEM_W_En = 1'b0;
    tick();
    bus.MEM_R_En = 1'b1;
    access("rd", 1'b1, 18'h20, 1'b0, 32'h0, 32'h12345678);
    bus.MEM_R_En = 1'b0;
    tick();

    // Dropped fetch with the address changing mid-access.
    bus.IF_Req = 1'b1; bus.IF_Addr = 18'h40;
    tick();
    check_eq("drop_c1_en", 32'(bus.Mem_En), 32'd1);
    check_eq("drop_c1_frz", 32'(bus.IF_Freeze), 32'd1);
    tick();
    bus.IF_Req = 1'b0; bus.IF_Addr = 18'h44;
    #1;
    check_eq("drop_c2_frz", 32'(bus.IF_Freeze), 32'd0);
    for (int c = 3; c <= 4; c++) begin
      tick();
      check_eq("drop_en", 32'(bus.Mem_En), 32'd1);
      check_eq("drop_addr", 32'(bus.Mem_Addr), 32'h40);
    end
    tick();
    check_eq("drop_if_rdy", 32'(bus.IF_Ready), 32'd1);
    check_eq("drop_if_data", bus.IF_Data, 32'h0BADF00D);
    tick();
    tick();
    check_eq("drop_no_regrant", 32'(bus.Mem_En), 32'd0);

    // Reset in cycle 2 of a data read: no Ready, access discarded, IDLE next cycle.
    bus.MEM_R_En = 1'b1; bus.MEM_Addr = 18'h30;
    tick();
    check_eq("rma_c1_en", 32'(bus.Mem_En), 32'd1);
    tick();
    rst = 1'b1;
    bus.MEM_R_En = 1'b0;
    tick();
    check_eq("rma_en", 32'(bus.Mem_En), 32'd0);
    check_eq("rma_ready", 32'({bus.IF_Ready, bus.MEM_Ready}), 32'd0);
    check_eq("rma_addr", 32'(bus.Mem_Addr), 32'd0);
    check_eq("rma_rdata", bus.MEM_Rdata, 32'd0);
    rst = 1'b0;
    bus.IF_Req = 1'b1; bus.IF_Addr = 18'h10;
    access("post_rst_i", 1'b0, 18'h10, 1'b0, 32'h0, 32'hDEADBEEF);
    bus.IF_Req = 1'b0;
    tick();

    // Minimum wait: one bus cycle, Ready in cycle 2.
    bus1.IF_Req = 1'b1; bus1.IF_Addr = 18'h10;
    tick();
    check_eq("w1_c1_en", 32'(bus1.Mem_En), 32'd1);
    check_eq("w1_c1_addr", 32'(bus1.Mem_Addr), 32'h10);
    check_eq("w1_c1_rdy", 32'(bus1.IF_Ready), 32'd0);
    tick();
    check_eq("w1_c2_rdy", 32'(bus1.IF_Ready), 32'd1);
    check_eq("w1_c2_en", 32'(bus1.Mem_En), 32'd0);
    check_eq("w1_c2_data", bus1.IF_Data, 32'hDEADBEEF);
    bus1.IF_Req = 1'b0;
    tick();
    check_eq("w1_c3_rdy", 32'(bus1.IF_Ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port instruction/data memory shared by the IF and MEM stages of the 5-stage pipeline. It grants one access at a time and holds address, data and control stable on the memory bus for a fixed number of wait cycles. It returns read data with a one-cycle Ready pulse. The pipeline freezes on the `*_Freeze` outputs exactly as it does on the hazard unit's Stall.

## Interface
- `ADDR_W`, 18: word-address width.
- `DATA_W`, 32: data width.
- `WAIT_CYC`, 4: cycles each access holds the memory bus; legal range 1..15.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `IF_Req`  in  1  instruction fetch request; held until `IF_Ready`.
- `IF_Addr`  in  ADDR_W  fetch address.
- `IF_Data`  out  DATA_W  fetched instruction.
- `IF_Ready`  out  1  one-cycle completion pulse for fetch.
- `IF_Freeze`  out  1  `IF_Req & ~IF_Ready`.
- `MEM_R_En`  in  1  data read request.
- `MEM_W_En`  in  1  data write request; never asserted together with `MEM_R_En`.
- `MEM_Addr`  in  ADDR_W  data address.
- `MEM_Wdata`  in  DATA_W  write data.
- `MEM_Rdata`  out  DATA_W  read data.
- `MEM_Ready`  out  1  one-cycle completion pulse for data read or write.
- `MEM_Freeze`  out  1  `(MEM_R_En | MEM_W_En) & ~MEM_Ready`.
- `Mem_En`  out  1  memory bus active.
- `Mem_Wr`  out  1  write strobe; valid only with `Mem_En`.
- `Mem_Addr`  out  ADDR_W  memory address.
- `Mem_Wdata`  out  DATA_W  memory write data.
- `Mem_Rdata`  in  DATA_W  memory read data; valid in the last wait cycle.

## Operation

The FSM has four states: IDLE, ACC_D, ACC_I and DONE.

- **IDLE**
  - If only a data request is present, grant data and go to ACC_D.
  - If only `IF_Req` is present, go to ACC_I.
  - If both are present, grant the requester not served last (`last_grant` flag, reset value = instruction, so data wins the first tie).
  - On grant, latch address, write data and write flag into the access registers, and load counter = `WAIT_CYC`-1.
- **ACC_D / ACC_I**
  - `Mem_En`=1, and the `Mem_*` outputs are driven from the latched registers, so they stay stable even if the requester's inputs change.
  - `Mem_Wr`=1 only for a latched data write.
  - The counter decrements each cycle.
  - When counter==0: capture `Mem_Rdata` into `MEM_Rdata` (data read) or `IF_Data` (fetch), update `last_grant`, and go to DONE.
- **DONE**
  - The matching Ready is asserted (Moore output), `Mem_En`=0.
  - Next state is always IDLE.
  - A new grant is evaluated only from IDLE, so back-to-back accesses are separated by one idle-bus cycle.
- **Data holding**: `IF_Data` and `MEM_Rdata` hold their value until the next completed access of the same kind. A write does not alter `MEM_Rdata`.
- **No abort**: if a request drops mid-access (e.g. a fetch flushed by a branch), the access still completes and Ready still pulses; the requester ignores it.
- **Reset values**: all outputs 0 and the FSM goes to IDLE.
- **Reset mid-access**: same effect, and the latched access is discarded.

## Timing
- A request sampled in IDLE at cycle 0 occupies the bus in cycles 1..`WAIT_CYC`.
- Ready is high in cycle `WAIT_CYC`+1, and the FSM is in IDLE in cycle `WAIT_CYC`+2.
- The requester advances on the edge ending the Ready cycle and must present its next request no earlier than that cycle's successor.
- Throughput: one access per `WAIT_CYC`+2 cycles.
- The Freeze outputs are combinational from request and Ready, with no register delay.
- `Mem_*` outputs are registered or decoded from state only; no input-to-`Mem_*` combinational path.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding constants (`S_IDLE`=2'd0, `S_ACC_D`=2'd1, `S_ACC_I`=2'd2, `S_DONE`=2'd3);
  - grant identifiers `GNT_I`=1'b0 and `GNT_D`=1'b1.
- One sub-module `mem_wait_counter`: 4-bit load/decrement counter with a `zero` flag.

## Test plan
- **Reset state**: hold `rst` 2 cycles with requests asserted → all outputs 0; first grant occurs the cycle after `rst` falls.
- **Fetch**: `WAIT_CYC`=4, fetch to `IF_Addr`=0x10, memory returns 0xDEADBEEF → `Mem_En` high cycles 1-4 with `Mem_Addr`=0x10, `IF_Ready` pulse in cycle 5, `IF_Data`=0xDEADBEEF, `IF_Freeze` low in cycle 5.
- **Write then read**: write 0x12345678 to 0x20, then read 0x20 → `Mem_Wr`=1 for exactly 4 cycles; the read returns 0x12345678 on `MEM_Rdata` with a `MEM_Ready` pulse; `MEM_Rdata` is unchanged after the write.
- **Simultaneous requests from reset**: data is served first, then the fetch; continuous dual requests alternate D, I, D, I with no requester waiting more than 2 access slots.
- **Dropped fetch**: `IF_Req` drops in cycle 2 → the bus stays on for all 4 cycles and `IF_Ready` still pulses in cycle 5; changing `IF_Addr` mid-access does not change `Mem_Addr`.
- **Reset mid-access and minimum wait**: `rst` in cycle 2 of an access gives `Mem_En`=0 and the FSM in IDLE next cycle, with no Ready pulse; `WAIT_CYC`=1 gives Ready in cycle 2.
